unlock_seq_ctrl: RTL and testbench
==================================

UNLOCK_SEQ_CTRL -- requirements
Module: unlock_seq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports named clock and ctrl_reset_n.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to accept a Hall level.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000: magnet-on duration in cycles.
REQ-004 SHALL have parameter STEP_TIMEOUT, default 5000: maximum cycles allowed between code steps.
REQ-005 SHALL have parameter MAX_FAILS, default 3: failures that trigger lockout.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 10000: lockout duration in cycles.
REQ-007 SHALL have the following ports:
- clock  in  1  system clock
- ctrl_reset_n  in  1  async active-low reset
- hall_in  in  4  raw Hall sensors H1..H4, active-high, asynchronous
- code  in  8  four 2-bit sensor indices; step0 = code[1:0], step3 = code[7:6]
- relock  in  1  force magnet off
- hall_db  out  4  debounced sensor levels feeding regfile sensor registers 1-4
- magnet  out  1  unlock magnet drive, feeding regfile register 10 bit 0
- busy  out  1  high in STEP
- fail_pulse  out  1  one-cycle pulse per failure
- state_o  out  2  current FSM state encoding

Function
REQ-008 SHALL synchronize each hall_in bit through 2 flops before debouncing.
REQ-009 SHALL update hall_db[i] only after the synchronized bit differs from hall_db[i] for DEB_CYCLES consecutive cycles; any glitch SHALL restart that count.
REQ-010 SHALL generate event[i] for one cycle on each 0->1 transition of hall_db[i].
REQ-011 SHALL implement states IDLE=0, STEP=1, OPEN=2, LOCKOUT=3, with a 2-bit step index and timer.
REQ-012 In IDLE, a single event matching code[1:0] SHALL latch code, set index=1 and enter STEP; any other event SHALL be a failure.
REQ-013 In STEP, an event matching the latched step[index] SHALL increment index and clear the timer; after index 3 matches, the FSM SHALL enter OPEN.
REQ-014 In STEP, a wrong event, or STEP_TIMEOUT cycles with no event, SHALL be a failure and return the FSM to IDLE.
REQ-015 Two or more simultaneous events in one cycle SHALL count as a wrong event.
REQ-016 magnet SHALL be 1 exactly while state is OPEN; it asserts on the clock edge after the final matching event.
REQ-017 OPEN SHALL last HOLD_CYCLES cycles and then go to IDLE; relock=1 SHALL move OPEN to IDLE on the next edge; events SHALL be ignored in OPEN.
REQ-018 relock in IDLE or STEP SHALL abort to IDLE without failure.
REQ-019 A failure SHALL pulse fail_pulse for one cycle and increment a saturating fail counter; entering OPEN SHALL clear the counter.
REQ-020 A change of code while in STEP SHALL NOT affect the sequence in progress.

Reset
REQ-021 While ctrl_reset_n=0, the block SHALL force state=IDLE, magnet=0, busy=0, fail_pulse=0, hall_db=0, and clear all counters and the latched code, asynchronously.
REQ-022 Reset asserted mid-OPEN SHALL drop magnet in the same cycle without waiting for a clock edge.

Configuration
REQ-023 With LOCKOUT_EN defined, reaching MAX_FAILS SHALL enter LOCKOUT for LOCKOUT_CYCLES cycles, ignoring events and relock, then enter IDLE with the fail counter cleared.
REQ-024 Without LOCKOUT_EN, LOCKOUT SHALL be unreachable and the fail counter SHALL only saturate.

Structure
REQ-025 Package unlock_pkg SHALL hold the state encoding constants and the code-step width (2).
REQ-026 Debounce SHALL be a sub-module hall_debounce, with one instance per sensor, parameterized by DEB_CYCLES.

Verification (bench parameters: DEB_CYCLES=2, HOLD_CYCLES=8, STEP_TIMEOUT=20, MAX_FAILS=3, LOCKOUT_CYCLES=16)
REQ-027 code=8'b11_10_01_00, pulse H1,H2,H3,H4 in order, each 6 cycles wide -> magnet=1 for exactly 8 cycles, fail_pulse never asserts.
REQ-028 A 1-cycle glitch on hall_in[0] -> hall_db stays 0 and state stays IDLE.
REQ-029 Correct H1 and H2, then H4 -> one fail_pulse and state IDLE; a correct H1 followed by 21 idle cycles -> fail_pulse and state IDLE.
REQ-030 With LOCKOUT_EN, 3 wrong events -> state=3 for 16 cycles; a correct sequence during lockout does not open; after 16 cycles the correct sequence opens.
REQ-031 relock asserted 3 cycles into OPEN -> magnet=0 on the next edge; ctrl_reset_n pulled low in OPEN -> magnet=0 immediately.
REQ-032 H1 and H2 rising in the same cycle while in IDLE -> fail_pulse, state stays IDLE.

Source files
------------

// File: rtl/unlock_pkg.sv
// Shared types and helpers for the Hall-sensor unlock sequencer.
// State encoding, code-step width and small decode functions.
package unlock_pkg;

    localparam int STEP_W    = 2;
    localparam int N_SENSORS = 4;
    localparam int N_STEPS   = 4;

    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when exactly one sensor produced an event this cycle.
    function automatic logic is_single(input logic [N_SENSORS-1:0] ev);
        return (ev != '0) && ((ev & (ev - 1'b1)) == '0);
    endfunction

    function automatic step_t sensor_index(input logic [N_SENSORS-1:0] ev);
        step_t idx;
        idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (ev[i]) idx = step_t'(i);
        end
        return idx;
    endfunction

    function automatic step_t code_step(input logic [N_STEPS*STEP_W-1:0] c, input step_t idx);
        step_t s;
        case (idx)
            2'd0:    s = c[1:0];
            2'd1:    s = c[3:2];
            2'd2:    s = c[5:4];
            default: s = c[7:6];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// One Hall sensor channel: two-flop synchronizer followed by a
// consecutive-sample debouncer that restarts on any glitch.
module hall_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic ctrl_reset_n,
    input  logic raw_in,
    output logic db_out
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/unlock_seq_ctrl.sv
// Four-step Hall-sensor unlock sequencer driving the unlock magnet.
// Define LOCKOUT_EN to enable the timed lockout after MAX_FAILS failures.
module unlock_seq_ctrl
    import unlock_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int HOLD_CYCLES    = 1000,
    parameter int STEP_TIMEOUT   = 5000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       ctrl_reset_n,
    input  logic [3:0] hall_in,
    input  logic [7:0] code,
    input  logic       relock,
    output logic [3:0] hall_db,
    output logic       magnet,
    output logic       busy,
    output logic       fail_pulse,
    output logic [1:0] state_o
);

    // One shared timer serves the step timeout, the hold time and the lockout.
    localparam int TMR_MAX = max3(HOLD_CYCLES, STEP_TIMEOUT, LOCKOUT_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FCNT_W  = $clog2(MAX_FAILS + 1);

    localparam logic [TMR_W-1:0]  STEP_END  = TMR_W'(STEP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  HOLD_END  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_SAT  = FCNT_W'(MAX_FAILS);
    localparam step_t             STEP_LAST = step_t'(N_STEPS - 1);
`ifdef LOCKOUT_EN
    localparam logic [TMR_W-1:0]  LOCK_END  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_TRIP = FCNT_W'(MAX_FAILS - 1);
`endif

    logic [N_SENSORS-1:0] db_prev_q;
    logic [N_SENSORS-1:0] events;
    logic                 ev_any;
    logic                 ev_single;
    step_t                ev_idx;

    state_e               state_q, state_d;
    step_t                idx_q, idx_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [7:0]           code_q, code_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic                 fail_q, fail_d;
    logic                 failure;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_deb
        hall_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clock        (clock),
            .ctrl_reset_n (ctrl_reset_n),
            .raw_in       (hall_in[i]),
            .db_out       (hall_db[i])
        );
    end

    assign events    = hall_db & ~db_prev_q;
    assign ev_any    = |events;
    assign ev_single = is_single(events);
    assign ev_idx    = sensor_index(events);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        fcnt_d  = fcnt_q;
        fail_d  = 1'b0;
        failure = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!relock && ev_any) begin
                    if (ev_single && ev_idx == code[1:0]) begin
                        code_d  = code;
                        idx_d   = step_t'(1);
                        tmr_d   = '0;
                        state_d = ST_STEP;
                    end else begin
                        failure = 1'b1;
                    end
                end
            end

            ST_STEP: begin
                if (relock) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    tmr_d   = '0;
                end else if (ev_any) begin
                    // Steps are compared against the code captured at the first step.
                    if (ev_single && ev_idx == code_step(code_q, idx_q)) begin
                        tmr_d = '0;
                        if (idx_q == STEP_LAST) begin
                            state_d = ST_OPEN;
                            idx_d   = '0;
                            fcnt_d  = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        failure = 1'b1;
                    end
                end else if (tmr_q == STEP_END) begin
                    failure = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_OPEN: begin
                if (relock || tmr_q == HOLD_END) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

`ifdef LOCKOUT_EN
            ST_LOCKOUT: begin
                if (tmr_q == LOCK_END) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    fcnt_d  = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        if (failure) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
            tmr_d   = '0;
            if (fcnt_q != FCNT_SAT) begin
                fcnt_d = fcnt_q + 1'b1;
            end
`ifdef LOCKOUT_EN
            if (fcnt_q >= FCNT_TRIP) begin
                state_d = ST_LOCKOUT;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tmr_q     <= '0;
            code_q    <= '0;
            fcnt_q    <= '0;
            fail_q    <= 1'b0;
            db_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmr_q     <= tmr_d;
            code_q    <= code_d;
            fcnt_q    <= fcnt_d;
            fail_q    <= fail_d;
            db_prev_q <= hall_db;
        end
    end

    // Decoded straight from the state flop so reset drops the magnet without a clock edge.
    assign magnet     = (state_q == ST_OPEN);
    assign busy       = (state_q == ST_STEP);
    assign fail_pulse = fail_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_unlock_seq_ctrl.sv
// Self-checking bench for unlock_seq_ctrl: directed scenarios plus
// randomized code/press sequences scored against a step-level model.
module tb_unlock_seq_ctrl;

    localparam int DEB  = 2;
    localparam int HOLD = 8;
    localparam int TOUT = 20;
    localparam int MAXF = 3;
    localparam int LOCK = 16;
`ifdef LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clock        = 1'b0;
    logic       ctrl_reset_n = 1'b1;
    logic [3:0] hall_in      = '0;
    logic [7:0] code         = '0;
    logic       relock       = 1'b0;
    logic [3:0] hall_db;
    logic       magnet;
    logic       busy;
    logic       fail_pulse;
    logic [1:0] state_o;

    unlock_seq_ctrl #(
        .DEB_CYCLES     (DEB),
        .HOLD_CYCLES    (HOLD),
        .STEP_TIMEOUT   (TOUT),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .hall_in      (hall_in),
        .code         (code),
        .relock       (relock),
        .hall_db      (hall_db),
        .magnet       (magnet),
        .busy         (busy),
        .fail_pulse   (fail_pulse),
        .state_o      (state_o)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Running cycle counts of interesting outputs, sampled on the falling edge.
    int mon_fail = 0;
    int mon_mag  = 0;
    int mon_lock = 0;
    int mon_db   = 0;
    always @(negedge clock) begin
        mon_fail <= mon_fail + (fail_pulse ? 1 : 0);
        mon_mag  <= mon_mag  + (magnet ? 1 : 0);
        mon_lock <= mon_lock + ((state_o == 2'd3) ? 1 : 0);
        mon_db   <= mon_db   + ((hall_db != 4'd0) ? 1 : 0);
    end

    int f0, m0, l0, d0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        f0 = mon_fail;
        m0 = mon_mag;
        l0 = mon_lock;
        d0 = mon_db;
    endtask

    task automatic pulse(input logic [3:0] m, input int hi, input int lo);
        hall_in = m;
        cyc(hi);
        hall_in = '0;
        cyc(lo);
    endtask

    task automatic do_reset();
        hall_in      = '0;
        relock       = 1'b0;
        ctrl_reset_n = 1'b0;
        cyc(2);
        ctrl_reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, input string tag);
        for (int i = 0; i < max && state_o !== s; i++) cyc(1);
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic wait_magnet(input int max, input string tag);
        for (int i = 0; i < max && magnet !== 1'b1; i++) cyc(1);
        check(tag, 32'(magnet), 32'd1);
    endtask

    // Sensor index the code asks for at step i (step0 in the low bits).
    function automatic int step_of(input logic [7:0] c, input int i);
        return (int'(c) >> (2 * i)) & 3;
    endfunction

    task automatic press_steps(input logic [7:0] c, input int first, input int last);
        for (int i = first; i <= last; i++) pulse(4'(1 << step_of(c, i)), 6, 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  s, idx, fails;
        bit  opened, locked;

        // Reset values, sampled before the first clock edge.
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("rst_state",  32'(state_o),    32'd0);
        check("rst_magnet", 32'(magnet),     32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_fail",   32'(fail_pulse), 32'd0);
        check("rst_hall_db", 32'(hall_db),   32'd0);
        cyc(2);
        ctrl_reset_n = 1'b1;
        cyc(2);

        // Correct four-step sequence opens for exactly HOLD cycles.
        code = 8'b11_10_01_00;
        snap();
        pulse(4'b0001, 6, 6);
        check("seq_busy",  32'(busy),    32'd1);
        check("seq_state", 32'(state_o), 32'd1);
        press_steps(code, 1, 3);
        cyc(20);
        check("seq_magnet_cycles", 32'(mon_mag - m0),  32'd8);
        check("seq_no_fail",       32'(mon_fail - f0), 32'd0);
        check("seq_back_idle",     32'(state_o),       32'd0);

        // One-cycle glitch never reaches the debounced output.
        snap();
        hall_in = 4'b0001;
        cyc(1);
        hall_in = '0;
        cyc(10);
        check("glitch_hall_db", 32'(mon_db - d0),   32'd0);
        check("glitch_state",   32'(state_o),       32'd0);
        check("glitch_no_fail", 32'(mon_fail - f0), 32'd0);

        // Wrong third step.
        do_reset();
        snap();
        pulse(4'b0001, 6, 6);
        pulse(4'b0010, 6, 6);
        pulse(4'b1000, 6, 6);
        cyc(4);
        check("wrong_step_fail",  32'(mon_fail - f0), 32'd1);
        check("wrong_step_state", 32'(state_o),       32'd0);
        check("wrong_step_mag",   32'(mon_mag - m0),  32'd0);

        // Step timeout after a correct first step.
        do_reset();
        snap();
        pulse(4'b0001, 6, 6);
        cyc(21);
        check("timeout_fail",  32'(mon_fail - f0), 32'd1);
        check("timeout_state", 32'(state_o),       32'd0);

        // Two sensors rising together in IDLE.
        do_reset();
        snap();
        pulse(4'b0011, 6, 6);
        check("dual_fail",  32'(mon_fail - f0), 32'd1);
        check("dual_state", 32'(state_o),       32'd0);

        // relock during STEP aborts quietly.
        do_reset();
        snap();
        pulse(4'b0001, 6, 6);
        check("abort_busy", 32'(busy), 32'd1);
        relock = 1'b1;
        cyc(1);
        relock = 1'b0;
        check("abort_state", 32'(state_o), 32'd0);
        cyc(25);
        check("abort_no_fail", 32'(mon_fail - f0), 32'd0);

        // Code changing mid-sequence does not disturb the latched code.
        do_reset();
        snap();
        code = 8'b00_01_10_11;
        pulse(4'b1000, 6, 6);
        code = 8'b11_10_01_00;
        pulse(4'b0100, 6, 6);
        pulse(4'b0010, 6, 6);
        pulse(4'b0001, 6, 6);
        cyc(20);
        check("latched_code_mag",  32'(mon_mag - m0),  32'd8);
        check("latched_code_fail", 32'(mon_fail - f0), 32'd0);

        // relock three cycles into OPEN.
        do_reset();
        code = 8'b11_10_01_00;
        press_steps(code, 0, 2);
        snap();
        hall_in = 4'b1000;
        wait_magnet(20, "relock_open_reached");
        cyc(2);
        relock = 1'b1;
        cyc(1);
        check("relock_magnet",  32'(magnet),       32'd0);
        check("relock_state",   32'(state_o),      32'd0);
        check("relock_mag_cyc", 32'(mon_mag - m0), 32'd3);
        relock  = 1'b0;
        hall_in = '0;
        cyc(10);
        check("relock_no_fail", 32'(mon_fail - f0), 32'd0);

        // Reset in OPEN drops the magnet without a clock edge.
        press_steps(code, 0, 2);
        hall_in = 4'b1000;
        wait_magnet(20, "rstopen_reached");
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("rstopen_magnet", 32'(magnet),  32'd0);
        check("rstopen_state",  32'(state_o), 32'd0);
        check("rstopen_hall",   32'(hall_db), 32'd0);
        hall_in = '0;
        cyc(2);
        ctrl_reset_n = 1'b1;
        cyc(2);

`ifdef LOCKOUT_EN
        // Third failure locks out; presses during lockout are ignored.
        snap();
        pulse(4'b0010, 6, 6);
        pulse(4'b0010, 6, 6);
        hall_in = 4'b0010;
        wait_state(2'd3, 12, "lock_enter");
        hall_in = 4'b0001;
        cyc(4);
        hall_in = 4'b0010;
        cyc(4);
        hall_in = '0;
        wait_state(2'd0, 30, "lock_exit");
        check("lock_cycles",   32'(mon_lock - l0), 32'd16);
        check("lock_fails",    32'(mon_fail - f0), 32'd3);
        check("lock_no_open",  32'(mon_mag - m0),  32'd0);
        cyc(6);
        press_steps(code, 0, 3);
        cyc(20);
        check("lock_then_open", 32'(mon_mag - m0), 32'd8);
`else
        // Without lockout the failure counter just saturates.
        snap();
        for (int i = 0; i < 4; i++) pulse(4'b0010, 6, 6);
        cyc(4);
        check("sat_fails",    32'(mon_fail - f0), 32'd4);
        check("sat_no_lock",  32'(mon_lock - l0), 32'd0);
        check("sat_state",    32'(state_o),       32'd0);
        press_steps(code, 0, 3);
        cyc(20);
        check("sat_then_open", 32'(mon_mag - m0), 32'd8);
`endif

        // Randomized sequences against a step-level model of the rules.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            code   = 8'($urandom);
            idx    = 0;
            fails  = 0;
            opened = 1'b0;
            locked = 1'b0;
            snap();
            for (int p = 0; p < 4; p++) begin
                if (idx < 4 && $urandom_range(9, 0) < 7) s = step_of(code, idx);
                else s = int'($urandom_range(3, 0));
                pulse(4'(1 << s), 6, 6);
                if (!locked && !opened) begin
                    if (s == step_of(code, idx)) begin
                        idx++;
                        if (idx == 4) opened = 1'b1;
                    end else begin
                        fails++;
                        idx = 0;
                        if (LOCK_EN && fails == MAXF) locked = 1'b1;
                    end
                end
            end
            if (!locked && !opened && idx != 0) fails++;
            cyc(60);
            check($sformatf("rand%0d_fails", t),  32'(mon_fail - f0), 32'(fails));
            check($sformatf("rand%0d_magnet", t), 32'(mon_mag - m0),  opened ? 32'd8 : 32'd0);
            check($sformatf("rand%0d_state", t),  32'(state_o),       32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
